// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter with a bounded ownership tenure.
//
// A master holds the bus while it keeps requesting, for at most TENURE
// consecutive cycles. Every release (voluntary or forced) is followed by
// exactly one idle GAP cycle. The search for the next owner always starts
// just after the most recently granted ID, so a master pushed off by its
// tenure limit goes to the back of the line.
//
// Ports:
//   clk        single clock, all state changes on posedge
//   rst_n      asynchronous active-low reset
//   request    bit k high = master with ID k+1 requests the bus
//   grant      ID of the current owner (1..NUM_MASTERS), 0 = bus idle
//   busy       high exactly when grant is nonzero
//   last_id    ID of the most recently granted master (round-robin pointer)
//   state_dbg  current FSM state (0 = IDLE, 1 = OWN, 2 = GAP)
//
// Handshake: there is no valid/ready pair here. A master signals interest by
// holding its request bit high and owns the bus for every cycle in which grant
// carries its ID; dropping the request bit ends ownership at the next posedge.
// All outputs are registered, so request changes are seen one edge later.

module bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int TENURE      = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] request,
  output logic [2:0]             grant,
  output logic                   busy,
  output logic [2:0]             last_id,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] grant_d;
  logic [2:0] last_d;
  logic [3:0] tenure_cnt, cnt_d;

  logic       win_found;
  logic [2:0] win_id;
  logic       owner_req;

  assign state_dbg = state_q;

  // Round-robin search: candidates are last_id+1 .. NUM_MASTERS, 1 .. last_id.
  // With last_id = 0 this degenerates to 1 .. NUM_MASTERS.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_id    = 3'd0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = ((int'(last_id) + i - 1) % NUM_MASTERS) + 1;
      if (!win_found && request[cand-1]) begin
        win_found = 1'b1;
        win_id    = 3'(cand);
      end
    end
  end

  // Request bit of the current owner; 0 when nobody owns the bus.
  always_comb begin
    owner_req = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant == 3'(k + 1)) owner_req = request[k];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant;
    last_d  = last_id;
    cnt_d   = tenure_cnt;
    case (state_q)
      // GAP arbitrates exactly like IDLE; it only exists to force one idle cycle.
      S_IDLE, S_GAP: begin
        if (win_found) begin
          state_d = S_OWN;
          grant_d = win_id;
          last_d  = win_id;
          cnt_d   = 4'd1;
        end else begin
          state_d = S_IDLE;
          grant_d = 3'd0;
        end
      end
      S_OWN: begin
        // Early release takes the same path as the forced one; the counter
        // stops at TENURE and therefore never wraps.
        if (!owner_req || tenure_cnt >= 4'(TENURE)) begin
          state_d = S_GAP;
          grant_d = 3'd0;
        end else begin
          cnt_d = tenure_cnt + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant      <= 3'd0;
      busy       <= 1'b0;
      last_id    <= 3'd0;
      tenure_cnt <= 4'd0;
    end else begin
      state_q    <= state_d;
      grant      <= grant_d;
      busy       <= (grant_d != 3'd0);
      last_id    <= last_d;
      tenure_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scoreboard bench for bus_arbiter (4 masters, tenure 3).
// The driver applies one request vector per cycle at the falling edge and
// queues the {grant, busy, last_id} expected after the following rising edge;
// the monitor pops one entry after each rising edge and compares.

module tb_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] request;
  logic [2:0] grant;
  logic       busy;
  logic [2:0] last_id;
  logic [1:0] state_dbg;

  logic [6:0] exp_q[$];
  int         n_total;
  int         n_pass;
  int         n_mon;

  bus_arbiter #(.NUM_MASTERS(4), .TENURE(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .request   (request),
    .grant     (grant),
    .busy      (busy),
    .last_id   (last_id),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got grant=%0d busy=%0d last_id=%0d, want grant=%0d busy=%0d last_id=%0d",
                  name, act[6:4], act[3], act[2:0], exp[6:4], exp[3], exp[2:0]);
  endtask

  // ---------------- driver ----------------
  // One cycle: apply rst_n/request, expect grant g and last_id l after the edge.
  task automatic step(input logic rst, input logic [3:0] req, input logic [2:0] g, input logic [2:0] l);
    @(negedge clk);
    rst_n   = rst;
    request = req;
    exp_q.push_back({g, (g != 3'd0), l});
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [6:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_mon++;
        check($sformatf("cycle%0d", n_mon), {grant, busy, last_id}, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_total = 0;
    n_pass  = 0;
    n_mon   = 0;
    rst_n   = 1'b0;
    request = 4'b0000;
    #2;
    check("reset_values", {grant, busy, last_id}, 7'd0);

    // Requests are ignored while reset is held.
    step(1'b0, 4'b1111, 3'd0, 3'd0);
    step(1'b0, 4'b1111, 3'd0, 3'd0);

    // Lone requester 2 held for 10 cycles: 2,2,2,0,2,2,2,0,2,2.
    step(1'b1, 4'b0010, 3'd2, 3'd2);
    step(1'b1, 4'b0010, 3'd2, 3'd2);
    step(1'b1, 4'b0010, 3'd2, 3'd2);
    step(1'b1, 4'b0010, 3'd0, 3'd2);
    step(1'b1, 4'b0010, 3'd2, 3'd2);
    step(1'b1, 4'b0010, 3'd2, 3'd2);
    step(1'b1, 4'b0010, 3'd2, 3'd2);
    step(1'b1, 4'b0010, 3'd0, 3'd2);
    step(1'b1, 4'b0010, 3'd2, 3'd2);
    step(1'b1, 4'b0010, 3'd2, 3'd2);
    step(1'b1, 4'b0000, 3'd0, 3'd2);  // early release -> GAP
    step(1'b1, 4'b0000, 3'd0, 3'd2);  // GAP -> IDLE

    // Early release: master 1 requests for a single cycle.
    step(1'b1, 4'b0001, 3'd1, 3'd1);
    step(1'b1, 4'b0000, 3'd0, 3'd1);
    step(1'b1, 4'b0000, 3'd0, 3'd1);

    // Fresh reset, then all four request continuously: 1,0,2,0,3,0,4,0.
    step(1'b0, 4'b0000, 3'd0, 3'd0);
    for (int id = 1; id <= 4; id++) begin
      for (int c = 0; c < 3; c++) step(1'b1, 4'b1111, 3'(id), 3'(id));
      step(1'b1, 4'b1111, 3'd0, 3'(id));
    end
    // Pointer wrap from last_id=4 with 1 and 4 requesting: 1 then 4.
    step(1'b1, 4'b1001, 3'd1, 3'd1);
    step(1'b1, 4'b1001, 3'd1, 3'd1);
    step(1'b1, 4'b1001, 3'd1, 3'd1);
    step(1'b1, 4'b1001, 3'd0, 3'd1);
    step(1'b1, 4'b1001, 3'd4, 3'd4);
    step(1'b1, 4'b1001, 3'd4, 3'd4);
    step(1'b1, 4'b1001, 3'd4, 3'd4);
    step(1'b1, 4'b1001, 3'd0, 3'd4);
    step(1'b1, 4'b0000, 3'd0, 3'd4);

    // Late non-owner request: 2 rises while 1 owns; 1 keeps its tenure.
    step(1'b1, 4'b0001, 3'd1, 3'd1);
    step(1'b1, 4'b0011, 3'd1, 3'd1);
    step(1'b1, 4'b0011, 3'd1, 3'd1);
    step(1'b1, 4'b0011, 3'd0, 3'd1);
    step(1'b1, 4'b0011, 3'd2, 3'd2);
    step(1'b1, 4'b0000, 3'd0, 3'd2);
    step(1'b1, 4'b0000, 3'd0, 3'd2);

    // Reset mid-tenure: grant 3, then asynchronous reset between edges.
    step(1'b1, 4'b1100, 3'd3, 3'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset", {grant, busy, last_id}, 7'd0);
    step(1'b0, 4'b1100, 3'd0, 3'd0);
    step(1'b1, 4'b1100, 3'd3, 3'd3);  // search restarts at ID 1
    step(1'b1, 4'b0000, 3'd0, 3'd3);
    step(1'b1, 4'b0000, 3'd0, 3'd3);

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    #2;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
